// File: rtl/div_fp_seq.sv
// div_fp_seq: sequential fixed-point divider, Q(N-FP).FP operands and result.
// Radix-2 restoring division, one quotient bit per clock, valid/ready handshake
// on both sides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (A dividend, B divisor)
//   out_valid, out_ready result handshake
//   OUT                 quotient A/B, same fixed-point format as the operands
//   ovrflow             true quotient does not fit in N bits
//   inv                 divisor was zero
//   busy                operation in progress or result pending
module div_fp_seq #(
    parameter int N      = 16,
    parameter int FP     = 8,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] OUT,
    output logic         ovrflow,
    output logic         inv,
    output logic         busy
);

    localparam int unsigned W  = N + FP;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Largest magnitudes representable for positive / negative signed results
    localparam logic [W-1:0] LIM_NEG = {{(W-1){1'b0}}, 1'b1} << (N - 1);
    localparam logic [W-1:0] LIM_POS = LIM_NEG - {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = ~SAT_POS;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dq_q, dq_d;     // dividend shifts out at the top, quotient shifts in at the bottom
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  div_q, div_d;
    logic          neg_q, neg_d;
    logic          bz_q, bz_d;
    logic [N-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d;
    logic          inv_q, inv_d;
    logic          ov_q, ov_d;

    // Operand magnitudes; |most-negative| wraps to 2^(N-1), which is correct unsigned
    logic          a_neg, b_neg;
    logic [N-1:0]  mag_a, mag_b;

    assign a_neg = (SIGNED != 0) && A[N-1];
    assign b_neg = (SIGNED != 0) && B[N-1];
    assign mag_a = a_neg ? -A : A;
    assign mag_b = b_neg ? -B : B;

    // One restoring step: N+1-bit partial remainder compared against the divisor
    logic [N:0] trial, diff;
    logic       ge;

    assign trial = {rem_q, dq_q[W-1]};
    assign diff  = trial - {1'b0, div_q};
    assign ge    = (trial >= {1'b0, div_q});

    // Result formatting from the completed magnitude quotient
    logic [W-1:0] q_signed;
    logic         fin_ovf;
    logic [N-1:0] fin_out;

    always_comb begin
        q_signed = neg_q ? -dq_q : dq_q;
        if (SIGNED != 0) begin
            fin_ovf = neg_q ? (dq_q > LIM_NEG) : (dq_q > LIM_POS);
        end else begin
            fin_ovf = ((dq_q >> N) != '0);
        end
        if (fin_ovf && (SAT != 0)) begin
            if (SIGNED == 0) begin
                fin_out = '1;
            end else begin
                fin_out = neg_q ? SAT_NEG : SAT_POS;
            end
        end else begin
            fin_out = q_signed[N-1:0];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            bz_q    <= bz_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        div_d   = div_q;
        neg_d   = neg_q;
        bz_d    = bz_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d   = mag_b;
                    dq_d    = W'(mag_a) << FP;
                    rem_d   = '0;
                    cnt_d   = '0;
                    neg_d   = a_neg ^ b_neg;
                    bz_d    = (B == '0);
                    state_d = (B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                rem_d = ge ? diff[N-1:0] : trial[N-1:0];
                dq_d  = {dq_q[W-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle latches the formatted result; afterwards hold until taken
                if (!ov_q) begin
                    ov_d  = 1'b1;
                    inv_d = bz_q;
                    ovf_d = bz_q ? 1'b0 : fin_ovf;
                    out_d = bz_q ? '0 : fin_out;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign OUT       = out_q;
    assign ovrflow   = ovf_q;
    assign inv       = inv_q;

endmodule

// File: tb/tb_div_fp_seq.sv
// Directed bench for div_fp_seq: three instances (unsigned saturating,
// unsigned wrapping, signed saturating) share one stimulus stream.
module tb_div_fp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a, b;

    logic        ir0, ov0, of0, iv0, bz0;
    logic [15:0] out0;
    logic        ir1, ov1, of1, iv1, bz1;
    logic [15:0] out1;
    logic        ir2, ov2, of2, iv2, bz2;
    logic [15:0] out2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_fp_seq #(.N(16), .FP(8), .SIGNED(0), .SAT(1)) u_us (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .A(a), .B(b),
        .out_valid(ov0), .out_ready(out_ready), .OUT(out0), .ovrflow(of0), .inv(iv0), .busy(bz0)
    );
    div_fp_seq #(.N(16), .FP(8), .SIGNED(0), .SAT(0)) u_uw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .A(a), .B(b),
        .out_valid(ov1), .out_ready(out_ready), .OUT(out1), .ovrflow(of1), .inv(iv1), .busy(bz1)
    );
    div_fp_seq #(.N(16), .FP(8), .SIGNED(1), .SAT(1)) u_ss (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .A(a), .B(b),
        .out_valid(ov2), .out_ready(out_ready), .OUT(out2), .ovrflow(of2), .inv(iv2), .busy(bz2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and count cycles until out_valid (bounded)
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        lat      = 0;
        while (ov0 !== 1'b1 && lat < 200) begin
            cyc();
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 16'h0300; b = 16'h0200;
        cyc(); cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov0); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir0); end
        total++; if (bz0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bz0); end
        total++; if ({out0, of0, iv0} !== 18'h0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b want=0000/0/0", out0, of0, iv0); end
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h0300, 16'h0200, lat);
        total++; if (lat !== 25) begin bad++; $display("FAIL basic_latency got=%0d want=25", lat); end
        total++; if (out0 !== 16'h0180) begin bad++; $display("FAIL basic_out got=%h want=0180", out0); end
        total++; if ({of0, iv0} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b%b want=00", of0, iv0); end
        total++; if (out2 !== 16'h0180) begin bad++; $display("FAIL basic_signed_out got=%h want=0180", out2); end
        retire();
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", ir0); end
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(16'h1234, 16'h0000, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
        total++; if (iv0 !== 1'b1) begin bad++; $display("FAIL dz_inv got=%b want=1", iv0); end
        total++; if ({out0, of0} !== 17'h0) begin bad++; $display("FAIL dz_out got=%h/%b want=0000/0", out0, of0); end
        retire();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(16'hFF00, 16'h0001, lat);
        total++; if (lat !== 25) begin bad++; $display("FAIL ovf_latency got=%0d want=25", lat); end
        total++; if ({of0, out0} !== {1'b1, 16'hFFFF}) begin bad++; $display("FAIL ovf_sat got=%b/%h want=1/FFFF", of0, out0); end
        total++; if ({of1, out1} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL ovf_wrap got=%b/%h want=1/0000", of1, out1); end
        total++; if ({of2, out2} !== {1'b1, 16'h8000}) begin bad++; $display("FAIL ovf_signed_neg got=%b/%h want=1/8000", of2, out2); end
        total++; if (iv0 !== 1'b0) begin bad++; $display("FAIL ovf_inv got=%b want=0", iv0); end
        retire();
    endtask

    task automatic test_signed();
        int lat;
        start_op(16'hFD00, 16'h0200, lat);
        total++; if ({of2, out2} !== {1'b0, 16'hFE80}) begin bad++; $display("FAIL sgn_neg_half got=%b/%h want=0/FE80", of2, out2); end
        retire();
        start_op(16'h8000, 16'hFF00, lat);
        total++; if ({of2, out2} !== {1'b1, 16'h7FFF}) begin bad++; $display("FAIL sgn_minneg got=%b/%h want=1/7FFF", of2, out2); end
        retire();
        start_op(16'h0780, 16'hFD80, lat);
        total++; if ({of2, out2} !== {1'b0, 16'hFD00}) begin bad++; $display("FAIL sgn_div_neg got=%b/%h want=0/FD00", of2, out2); end
        retire();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h0300, 16'h0200, lat);
        for (int i = 0; i < 5; i++) begin
            a = 16'h1111; b = 16'h0001; in_valid = 1'b1;
            cyc();
            total++; if ({ov0, ir0, out0} !== {1'b1, 1'b0, 16'h0180}) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h want=1/0/0180", i, ov0, ir0, out0);
            end
        end
        in_valid = 1'b0;
        retire();
        total++; if ({ir0, ov0} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b%b want=10", ir0, ov0); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen;
        a = 16'h0300; b = 16'h0200; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        total++; if ({bz0, ir0} !== 2'b10) begin bad++; $display("FAIL mid_busy got=%b%b want=10", bz0, ir0); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if ({ir0, bz0, ov0} !== 3'b100) begin bad++; $display("FAIL mid_abort got=%b%b%b want=100", ir0, bz0, ov0); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (ov0 === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", seen); end
        start_op(16'h0500, 16'h0400, lat);
        total++; if ({lat[7:0], out0} !== {8'd25, 16'h0140}) begin bad++; $display("FAIL mid_new_op got=%0d/%h want=25/0140", lat, out0); end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(16'h0A00, 16'h0500, lat);
        total++; if (out0 !== 16'h0200) begin bad++; $display("FAIL b2b_first got=%h want=0200", out0); end
        retire();
        start_op(16'h0100, 16'h0400, lat);
        total++; if ({lat[7:0], out0} !== {8'd25, 16'h0040}) begin bad++; $display("FAIL b2b_second got=%0d/%h want=25/0040", lat, out0); end
        retire();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
